fwd_hazard_unit: RTL and testbench

Parametrised forwarding and hazard unit for the integer/float pipeline. It generates per-source bypass selects for EX from any number of downstream write stages. It also keeps a sequential scoreboard of in-flight multi-cycle results, with fixed-latency countdown and variable-latency completion tracking, and stalls ID on RAW/WAW hazards against that scoreboard. Sits between ID/EX pipeline registers and the EX operand muxes; replaces the fixed two-stage, three-source forwarding logic.

---
 rtl/fwd_hazard_unit.sv | 131 +++++++++++++
 tb/tb_fwd_hazard_unit.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fwd_hazard_unit.sv
// Forwarding and hazard unit: per-source EX bypass selects from NSTG write stages,
// plus an ID-stage scoreboard of fixed/variable-latency results driving stall.
module fwd_hazard_unit #(
  parameter int NSRC    = 3,
  parameter int NSTG    = 2,
  parameter int MAX_LAT = 7,
  parameter int MAX_OUT = 4,
  parameter int CW      = $clog2(MAX_LAT + 1),
  parameter int SELW    = $clog2(NSTG + 1),
  parameter int OW      = $clog2(MAX_OUT + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NSTG-1:0]      stg_wen_x,
  input  logic [NSTG-1:0]      stg_wen_f,
  input  logic [5*NSTG-1:0]    stg_rd,
  input  logic [5*NSRC-1:0]    ex_rs,
  input  logic [NSRC-1:0]      ex_rs_f,
  input  logic [NSRC-1:0]      ex_rs_used,
  output logic [SELW*NSRC-1:0] fwd_sel,
  input  logic [5*NSRC-1:0]    id_rs,
  input  logic [NSRC-1:0]      id_rs_f,
  input  logic [NSRC-1:0]      id_rs_used,
  input  logic                 id_issue,
  input  logic [4:0]           id_rd,
  input  logic                 id_rd_f,
  input  logic                 id_rd_wen,
  input  logic [CW-1:0]        id_lat,
  input  logic                 id_var,
  input  logic                 done_valid,
  input  logic [4:0]           done_rd,
  input  logic                 done_f,
  output logic                 stall,
  output logic [OW-1:0]        out_cnt
);

  // Forwarding: nearest matching stage wins, integer x0 never matches.
  for (genvar gi = 0; gi < NSRC; gi++) begin : g_fwd
    logic [4:0]      rs;
    logic [SELW-1:0] sel;
    assign rs = ex_rs[5*gi +: 5];
    always_comb begin
      sel = '0;
      for (int k = NSTG - 1; k >= 0; k--) begin
        if (ex_rs_used[gi] && (ex_rs_f[gi] ? stg_wen_f[k] : stg_wen_x[k]) &&
            (stg_rd[5*k +: 5] == rs) && (ex_rs_f[gi] || rs != 5'd0))
          sel = SELW'(k + 1);
      end
    end
    assign fwd_sel[SELW*gi +: SELW] = sel;
  end

  // Scoreboard state, index [file][reg] with file 0 = integer, 1 = float.
  logic [1:0][31:0]         pend_reg;
  logic [1:0][31:0]         var_reg;
  logic [1:0][31:0][CW-1:0] cnt_reg;
  logic [OW-1:0]            out_cnt_reg;
  logic [1:0][31:0]         set_hit;
  logic [1:0][31:0]         done_hit;
  logic                     set_en;
  logic                     var_set;
  logic                     var_done;

  // Excluding x0 here keeps integer entry 0 permanently clear.
  assign set_en = id_issue && id_rd_wen && (id_var || id_lat != '0) &&
                  (id_rd_f || id_rd != 5'd0);

  for (genvar gf = 0; gf < 2; gf++) begin : g_file
    for (genvar gi = 0; gi < 32; gi++) begin : g_ent
      assign set_hit[gf][gi]  = set_en && (id_rd_f == 1'(gf)) && (id_rd == 5'(gi));
      assign done_hit[gf][gi] = done_valid && (done_f == 1'(gf)) && (done_rd == 5'(gi)) &&
                                pend_reg[gf][gi] && var_reg[gf][gi];
    end
  end

  assign var_set  = set_en && id_var;
  assign var_done = |done_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_reg <= '0;
      var_reg  <= '0;
      cnt_reg  <= '0;
    end else begin
      for (int f = 0; f < 2; f++) begin
        for (int i = 0; i < 32; i++) begin
          if (set_hit[f][i]) begin
            pend_reg[f][i] <= 1'b1;
            var_reg[f][i]  <= id_var;
            cnt_reg[f][i]  <= id_var ? '0 : id_lat;
          end else if (done_hit[f][i]) begin
            pend_reg[f][i] <= 1'b0;
            var_reg[f][i]  <= 1'b0;
          end else if (pend_reg[f][i] && !var_reg[f][i]) begin
            if (cnt_reg[f][i] == CW'(1)) begin
              pend_reg[f][i] <= 1'b0;
              cnt_reg[f][i]  <= '0;
            end else begin
              cnt_reg[f][i] <= cnt_reg[f][i] - CW'(1);
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      out_cnt_reg <= '0;
    else if (var_set && !var_done)
      out_cnt_reg <= out_cnt_reg + OW'(1);
    else if (!var_set && var_done)
      out_cnt_reg <= out_cnt_reg - OW'(1);
  end

  assign out_cnt = out_cnt_reg;

  // Stall looks only at registered state; completions are not bypassed.
  always_comb begin
    stall = 1'b0;
    for (int j = 0; j < NSRC; j++) begin
      if (id_rs_used[j] && pend_reg[id_rs_f[j]][id_rs[5*j +: 5]])
        stall = 1'b1;
    end
    if (id_rd_wen && pend_reg[id_rd_f][id_rd])
      stall = 1'b1;
    if (id_var && out_cnt_reg == OW'(MAX_OUT))
      stall = 1'b1;
  end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Bench for fwd_hazard_unit: directed scenarios then randomized traffic
// compared against a ready-time based scoreboard model.
module tb_fwd_hazard_unit;
  localparam int NSRC    = 3;
  localparam int NSTG    = 2;
  localparam int MAX_LAT = 7;
  localparam int MAX_OUT = 4;
  localparam int CW      = $clog2(MAX_LAT + 1);
  localparam int SELW    = $clog2(NSTG + 1);
  localparam int OW      = $clog2(MAX_OUT + 1);

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic [NSTG-1:0]      stg_wen_x, stg_wen_f;
  logic [5*NSTG-1:0]    stg_rd;
  logic [5*NSRC-1:0]    ex_rs, id_rs;
  logic [NSRC-1:0]      ex_rs_f, ex_rs_used, id_rs_f, id_rs_used;
  logic [SELW*NSRC-1:0] fwd_sel;
  logic                 id_issue, id_rd_f, id_rd_wen, id_var;
  logic [4:0]           id_rd, done_rd;
  logic [CW-1:0]        id_lat;
  logic                 done_valid, done_f;
  logic                 stall;
  logic [OW-1:0]        out_cnt;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  fwd_hazard_unit #(.NSRC(NSRC), .NSTG(NSTG), .MAX_LAT(MAX_LAT), .MAX_OUT(MAX_OUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .stg_wen_x(stg_wen_x), .stg_wen_f(stg_wen_f), .stg_rd(stg_rd),
    .ex_rs(ex_rs), .ex_rs_f(ex_rs_f), .ex_rs_used(ex_rs_used), .fwd_sel(fwd_sel),
    .id_rs(id_rs), .id_rs_f(id_rs_f), .id_rs_used(id_rs_used),
    .id_issue(id_issue), .id_rd(id_rd), .id_rd_f(id_rd_f), .id_rd_wen(id_rd_wen),
    .id_lat(id_lat), .id_var(id_var),
    .done_valid(done_valid), .done_rd(done_rd), .done_f(done_f),
    .stall(stall), .out_cnt(out_cnt)
  );

  task automatic chk(input string tag, input int unsigned obs, input int unsigned exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic idle();
    stg_wen_x = '0; stg_wen_f = '0; stg_rd = '0;
    ex_rs = '0; ex_rs_f = '0; ex_rs_used = '0;
    id_rs = '0; id_rs_f = '0; id_rs_used = '0;
    id_issue = 1'b0; id_rd = '0; id_rd_f = 1'b0; id_rd_wen = 1'b0;
    id_lat = '0; id_var = 1'b0;
    done_valid = 1'b0; done_rd = '0; done_f = 1'b0;
  endtask

  // Called at a negedge; issues across one posedge, returns at the following negedge.
  task automatic issue_op(input logic [4:0] rd, input logic f, input int lat, input logic v);
    id_issue = 1'b1; id_rd = rd; id_rd_f = f; id_rd_wen = 1'b1;
    id_lat = CW'(lat); id_var = v;
    @(posedge clk);
    @(negedge clk);
    id_issue = 1'b0; id_rd_wen = 1'b0; id_lat = '0; id_var = 1'b0;
  endtask

  // Reference model: fixed results are busy until an absolute edge number,
  // variable results until their completion is seen.
  bit vpend[2][32];
  int free_at[2][32];
  int m_out;
  int e_last;

  task automatic m_reset();
    for (int f = 0; f < 2; f++)
      for (int r = 0; r < 32; r++) begin
        vpend[f][r] = 1'b0;
        free_at[f][r] = 0;
      end
    m_out = 0;
    e_last = 0;
  endtask

  function automatic bit m_pend(input int f, input int r);
    return vpend[f][r] || (e_last < free_at[f][r]);
  endfunction

  function automatic logic [SELW*NSRC-1:0] m_fwd();
    logic [SELW*NSRC-1:0] s;
    s = '0;
    for (int j = 0; j < NSRC; j++) begin
      int pick;
      int rs;
      pick = 0;
      rs = int'(ex_rs[5*j +: 5]);
      for (int k = 0; k < NSTG; k++) begin
        bit wen;
        wen = ex_rs_f[j] ? stg_wen_f[k] : stg_wen_x[k];
        if (pick == 0 && ex_rs_used[j] && wen && int'(stg_rd[5*k +: 5]) == rs &&
            (ex_rs_f[j] || rs != 0))
          pick = k + 1;
      end
      s[SELW*j +: SELW] = SELW'(pick);
    end
    return s;
  endfunction

  function automatic bit m_stall();
    bit s;
    s = 1'b0;
    for (int j = 0; j < NSRC; j++)
      if (id_rs_used[j] && m_pend(int'(id_rs_f[j]), int'(id_rs[5*j +: 5]))) s = 1'b1;
    if (id_rd_wen && m_pend(int'(id_rd_f), int'(id_rd))) s = 1'b1;
    if (id_var && m_out == MAX_OUT) s = 1'b1;
    return s;
  endfunction

  task automatic m_step();
    e_last++;
    if (done_valid && vpend[done_f][done_rd]) begin
      vpend[done_f][done_rd] = 1'b0;
      m_out--;
    end
    if (id_issue && id_rd_wen && (id_var || id_lat != 0) && !(!id_rd_f && id_rd == 0)) begin
      if (id_var) begin
        vpend[id_rd_f][id_rd] = 1'b1;
        free_at[id_rd_f][id_rd] = 0;
        m_out++;
      end else begin
        vpend[id_rd_f][id_rd] = 1'b0;
        free_at[id_rd_f][id_rd] = e_last + int'(id_lat);
      end
      $display("issue %s%0d lat=%0d var=%0d outstanding=%0d", id_rd_f ? "f" : "x",
               id_rd, id_lat, id_var, m_out);
    end
  endtask

  initial begin
    bit exp_s;
    idle();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("reset_fwd", fwd_sel, 0);
    chk("reset_stall", stall, 0);
    chk("reset_out_cnt", out_cnt, 0);

    // Forwarding priority and file/x0 rules
    stg_wen_x = 2'b11; stg_rd = {5'd7, 5'd7}; ex_rs[4:0] = 5'd7; ex_rs_used[0] = 1'b1;
    #1 chk("fwd_prio_nearest", fwd_sel[1:0], 1);
    stg_wen_x = 2'b10;
    #1 chk("fwd_prio_far", fwd_sel[1:0], 2);
    ex_rs[14:10] = 5'd7; ex_rs_used[2] = 1'b1;
    #1 chk("fwd_src2", fwd_sel[5:4], 2);
    idle();
    stg_wen_x = 2'b01; stg_rd = '0; ex_rs_used[0] = 1'b1;
    #1 chk("fwd_x0", fwd_sel[1:0], 0);
    stg_wen_x = 2'b00; stg_wen_f = 2'b01; ex_rs_f[0] = 1'b1;
    #1 chk("fwd_f0", fwd_sel[1:0], 1);
    stg_wen_x = 2'b01; stg_wen_f = 2'b00; stg_rd[4:0] = 5'd5; ex_rs[4:0] = 5'd5;
    #1 chk("fwd_cross_file", fwd_sel[1:0], 0);
    idle();

    // Fixed latency 3 on f3: dependent stalls exactly three cycles
    @(negedge clk);
    issue_op(5'd3, 1'b1, 3, 1'b0);
    id_rs[4:0] = 5'd3; id_rs_f[0] = 1'b1; id_rs_used[0] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1 chk("fix_stall", stall, (i < 3) ? 1 : 0);
      @(negedge clk);
    end
    idle();

    // Variable op on x9 until completion
    issue_op(5'd9, 1'b0, 0, 1'b1);
    id_rs[4:0] = 5'd9; id_rs_used[0] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1 chk("var_stall", stall, 1);
      chk("var_out_cnt", out_cnt, 1);
      @(negedge clk);
    end
    done_valid = 1'b1; done_rd = 5'd9; done_f = 1'b0;
    #1 chk("var_stall_done_cycle", stall, 1);
    @(negedge clk);
    done_valid = 1'b0;
    #1 chk("var_stall_after", stall, 0);
    chk("var_out_cnt_after", out_cnt, 0);
    idle();

    // Occupancy limit and simultaneous issue/done
    for (int r = 1; r <= 4; r++) issue_op(5'(r), 1'b0, 0, 1'b1);
    #1 chk("occ_out_cnt_full", out_cnt, 4);
    id_var = 1'b1; id_rd = 5'd5; id_rd_wen = 1'b1;
    #1 chk("occ_stall", stall, 1);
    id_issue = 1'b1; done_valid = 1'b1; done_rd = 5'd1; done_f = 1'b0;
    @(negedge clk);
    idle();
    #1 chk("occ_swap_out_cnt", out_cnt, 4);
    id_rs[4:0] = 5'd1; id_rs_used[0] = 1'b1;
    #1 chk("occ_x1_cleared", stall, 0);
    id_rs[4:0] = 5'd5;
    #1 chk("occ_x5_pending", stall, 1);
    idle();

    // Asynchronous reset mid-count
    issue_op(5'd6, 1'b0, 7, 1'b0);
    @(negedge clk);
    id_rs[4:0] = 5'd6; id_rs_used[0] = 1'b1;
    #1 chk("rst_pre_stall", stall, 1);
    #2 rst_n = 1'b0;
    #1 chk("rst_async_stall", stall, 0);
    chk("rst_async_out_cnt", out_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("rst_release_stall", stall, 0);
    idle();

    // Randomized traffic against the model
    m_reset();
    for (int n = 0; n < 1500; n++) begin
      @(negedge clk);
      stg_wen_x = NSTG'($urandom); stg_wen_f = NSTG'($urandom);
      for (int k = 0; k < NSTG; k++) stg_rd[5*k +: 5] = 5'($urandom_range(0, 7));
      for (int j = 0; j < NSRC; j++) begin
        ex_rs[5*j +: 5] = 5'($urandom_range(0, 7));
        id_rs[5*j +: 5] = 5'($urandom_range(0, 7));
      end
      ex_rs_f = NSRC'($urandom); ex_rs_used = NSRC'($urandom);
      id_rs_f = NSRC'($urandom); id_rs_used = NSRC'($urandom);
      id_rd = 5'($urandom_range(0, 7)); id_rd_f = 1'($urandom); id_rd_wen = 1'($urandom);
      id_lat = CW'($urandom_range(0, MAX_LAT)); id_var = ($urandom_range(0, 3) == 0);
      done_valid = ($urandom_range(0, 1) == 0);
      done_rd = 5'($urandom_range(0, 7)); done_f = 1'($urandom);
      id_issue = 1'b0;
      exp_s = m_stall();
      id_issue = ($urandom_range(0, 1) == 1) && !exp_s;
      #1;
      chk("rnd_fwd_sel", fwd_sel, m_fwd());
      chk("rnd_stall", stall, exp_s);
      chk("rnd_out_cnt", out_cnt, m_out);
      @(posedge clk);
      m_step();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
